load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encoding,
// controller states and the size/alignment legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_e;

    // Address range is checked separately because it depends on N.
    function automatic logic misaligned(size_e sz, logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        unique case (sz)
            SZ_B:   bad = 1'b0;
            SZ_H:   bad = lo[0];
            SZ_W:   bad = (lo != 2'b00);
            SZ_BAD: bad = 1'b1;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane extraction with sign/zero extension for loads,
// and lane replacement for sub-word store read-modify-write.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rdata,
    input  logic [1:0]   lo,
    input  size_e        size,
    input  logic         uns,
    input  logic [15:0]  wdata,
    output logic [W-1:0] ldata,
    output logic [W-1:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = rdata[{lo, 3'b000} +: 8];
        h      = rdata[{lo[1], 4'b0000} +: 16];
        ldata  = rdata;
        merged = rdata;
        unique case (size)
            SZ_B: begin
                ldata = uns ? {{(W-8){1'b0}}, b}
                            : {{(W-8){b[7]}}, b};
                merged[{lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ldata = uns ? {{(W-16){1'b0}}, h}
                            : {{(W-16){h[15]}}, h};
                merged[{lo[1], 4'b0000} +: 16] = wdata;
            end
            default: begin
                ldata  = rdata;
                merged = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed
// data memory with one-cycle registered read data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_rdata,
    output logic         resp_err,
    output logic [W-1:0] mem_address,
    output logic         mem_read,
    output logic         mem_write,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    state_e         state;
    logic           we_q;
    logic           uns_q;
    size_e          size_q;
    logic [N+1:0]   addr_q;
    logic [W-1:0]   wdata_q;
    logic [W-1:0]   merged_q;
    logic           rd_q;
    logic           wr_q;

    logic [W-1:0]   ldata;
    logic [W-1:0]   merged;
    logic [W-1:0]   widx;
    logic           acc;
    logic           req_err;
    logic           word_st;
    logic           req_word_st;

    assign req_ready   = (state == IDLE);
    assign acc         = req_valid && req_ready;
    assign req_err     = misaligned(size_e'(req_size), req_addr[1:0])
                       || ((req_addr >> (N + 2)) != '0);
    assign req_word_st = req_we && (size_e'(req_size) == SZ_W);
    assign word_st     = we_q && (size_q == SZ_W);
    assign widx        = {{(W-N){1'b0}}, addr_q[N+1:2]};

    // Strobes drop with rst so a reset in WRITE never commits.
    assign mem_read    = rd_q && !rst;
    assign mem_write   = wr_q && !rst;

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        unique case (1'b1)
            (state == ISSUE): begin
                mem_address = widx;
                mem_wdata   = word_st ? wdata_q : '0;
            end
            (state == WRITE): begin
                mem_address = widx;
                mem_wdata   = merged_q;
            end
            default: begin
                mem_address = '0;
                mem_wdata   = '0;
            end
        endcase
    end

    lsu_align #(
        .W(W)
    ) u_align (
        .rdata  (mem_rdata),
        .lo     (addr_q[1:0]),
        .size   (size_q),
        .uns    (uns_q),
        .wdata  (wdata_q[15:0]),
        .ldata  (ldata),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= size_e'(req_size);
                        addr_q  <= req_addr[N+1:0];
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ISSUE;
                            if (req_word_st) begin
                                wr_q <= 1'b1;
                            end else begin
                                rd_q <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (word_st) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (we_q) begin
                        merged_q <= merged;
                        wr_q     <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        resp_rdata <= ldata;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WRITE: begin
                    wr_q       <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory
// model, with directed sequences pinning literal results.
module tb_load_store_unit;

    localparam int W = 32;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_rdata;
    logic         resp_err;
    logic [W-1:0] mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    logic [31:0] mem [32];
    logic [31:0] pre [32];
    logic        preload;
    logic [7:0]  gold [128];

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] exp_widx = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= pre[i];
        end else begin
            if (mem_write) mem[mem_address[4:0]] <= mem_wdata;
            if (mem_read) mem_rdata <= mem[mem_address[4:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            chk("mem_excl", {31'd0, mem_read && mem_write}, 32'd0);
            chk("mem_addr", mem_address, exp_widx);
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
        end
    end

    function automatic bit m_err(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0])
            || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd128);
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, bit uns,
                                           logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = {24'd0, gold[a]};
            if (!uns && v[7]) v[31:8] = 24'hFFFFFF;
        end else if (sz == 2'd1) begin
            v = {16'd0, gold[a+1], gold[a]};
            if (!uns && v[15]) v[31:16] = 16'hFFFF;
        end else begin
            v = {gold[a+3], gold[a+2], gold[a+1], gold[a]};
        end
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
        int nb;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < nb; i++) gold[a+i] = wd[8*i +: 8];
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] got, output int lat);
        bit e;
        logic [31:0] exp_rd;
        int exp_lat, erd, ewr;
        e = m_err(sz, a);
        exp_rd = (e || we) ? 32'd0 : m_load(sz, uns, a);
        exp_lat = e ? 1 : we ? ((sz == 2'd2) ? 2 : 4) : 3;
        erd = (e || (we && sz == 2'd2)) ? 0 : 1;
        ewr = (!e && we) ? 1 : 0;
        exp_widx = {27'd0, a[6:2]};
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        rd_cnt = 0;
        wr_cnt = 0;
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'($urandom_range(0, 1));
        req_we = 1'($urandom);
        req_size = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e});
        chk("resp_rdata", resp_rdata, exp_rd);
        got = resp_rdata;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err", {31'd0, resp_err}, {31'd0, e});
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_release", {31'd0, resp_valid}, 32'd0);
        chk("ready_back", {31'd0, req_ready}, 32'd1);
        chk("rd_count", rd_cnt, erd);
        chk("wr_count", wr_cnt, ewr);
        if (ewr == 1) m_store(sz, a, wd);
    endtask

    initial begin
        logic [31:0] g, saved, a;
        int l, guard;
        logic [1:0] sz;

        rst = 1'b1;
        preload = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pre[i] = $urandom;
            for (int b = 0; b < 4; b++) gold[4*i+b] = pre[i][8*b +: 8];
        end
        @(posedge clk); #1;
        preload = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mrd", {31'd0, mem_read}, 32'd0);
        chk("rst_mwr", {31'd0, mem_write}, 32'd0);
        chk("rst_maddr", mem_address, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);

        do_req(1, 2'd2, 0, 32'h08, 32'hDEADBEEF, 0, g, l);
        chk("lit_sw_lat", l, 32'd2);
        do_req(0, 2'd2, 0, 32'h08, 32'h0, 0, g, l);
        chk("lit_lw_data", g, 32'hDEADBEEF);
        chk("lit_lw_lat", l, 32'd3);

        do_req(1, 2'd2, 0, 32'h10, 32'h000080F0, 0, g, l);
        do_req(0, 2'd0, 0, 32'h11, 32'h0, 0, g, l);
        chk("lit_lb", g, 32'hFFFFFF80);
        do_req(0, 2'd0, 1, 32'h11, 32'h0, 0, g, l);
        chk("lit_lbu", g, 32'h00000080);

        do_req(1, 2'd2, 0, 32'h20, 32'h11223344, 0, g, l);
        do_req(1, 2'd0, 0, 32'h22, 32'h000000AA, 0, g, l);
        chk("lit_sb_lat", l, 32'd4);
        do_req(1, 2'd1, 0, 32'h20, 32'h0000BEEF, 1, g, l);
        chk("lit_sh_lat", l, 32'd4);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 0, g, l);
        chk("lit_merge", g, 32'h11AABEEF);

        do_req(0, 2'd1, 0, 32'h03, 32'h0, 0, g, l);
        chk("lit_err_lh", l, 32'd1);
        do_req(1, 2'd2, 0, 32'h06, 32'h1234, 0, g, l);
        chk("lit_err_sw", l, 32'd1);
        do_req(0, 2'd3, 0, 32'h00, 32'h0, 0, g, l);
        chk("lit_err_sz", l, 32'd1);
        do_req(0, 2'd2, 0, 32'h80, 32'h0, 0, g, l);
        chk("lit_err_rng", l, 32'd1);

        do_req(0, 2'd2, 0, 32'h20, 32'h0, 5, g, l);

        saved = {gold[51], gold[50], gold[49], gold[48]};
        exp_widx = 32'd12;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'h31;
        req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!mem_write && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rst_reach_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_write", {31'd0, mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_idle", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_mem_kept", mem[12], saved);

        for (int k = 0; k < 200; k++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 127);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'd0;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                   $urandom_range(0, 3), g, l);
        end

        for (int i = 0; i < 32; i++) begin
            chk("final_mem", mem[i],
                {gold[4*i+3], gold[4*i+2], gold[4*i+1], gold[4*i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
